toggle_event_decoder: RTL and testbench
=======================================

Name: toggle_event_decoder

Overview:
- Receive-side decoder for toggle-encoded event signalling. A transmitter flips a single level line (T flip-flop style) once per event; this block recovers one event per transition.
- Synchronises the asynchronous toggle line into clk, detects each transition and queues events in a saturating pending counter.
- Delivers queued events to a consumer over a valid/ready handshake, one event per accepted transfer.
- Sits at the destination clock domain of any toggle-based event or pulse crossing.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on tog_in; legal range 2..4.
- CNT_W, 3, width of the pending-event counter; capacity is 2^CNT_W-1 events.
- TOT_W, 16, width of the free-running accepted-event counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- tog_in  input  1  asynchronous toggle line from the transmitter; each level change is one event.
- evt_valid  output  1  high while at least one event is pending.
- evt_ready  input  1  consumer accepts one event on a clock edge where evt_valid && evt_ready.
- pending  output  CNT_W  number of queued, not-yet-accepted events.
- overflow  output  1  sticky flag: an event was dropped because the counter was full.
- ovf_clr  input  1  synchronous clear of overflow.
- total_cnt  output  TOT_W  count of accepted events; wraps modulo 2^TOT_W.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All synchroniser flops and the edge-history flop are loaded with 0.
  - pending=0, evt_valid=0, overflow=0, total_cnt=0.
  - Reset overrides every other input in that cycle.
  - The transmitter's toggle flop also resets to 0. If tog_in is 1 after reset release, exactly one event is counted; this is legal, documented behaviour.
- Synchroniser:
  - s[0] samples tog_in; s[k] samples s[k-1]; sync = s[SYNC_STAGES-1].
  - No logic is placed between the stages.
- Edge detect:
  - hist is registered from sync every cycle.
  - evt = sync XOR hist (combinational, single-cycle).
  - Either polarity of change counts as one event.
- Latency:
  - A tog_in change set up before edge E reaches sync at edge E+SYNC_STAGES-1.
  - pending increments at edge E+SYNC_STAGES.
  - evt_valid is high after edge E+SYNC_STAGES. For SYNC_STAGES=2 this is 2 edges.
- Handshake:
  - Define acc = evt_valid && evt_ready.
  - evt_valid is a registered-state decode: evt_valid = (pending != 0). It is never combinationally dependent on evt_ready.
  - A consumer holding evt_ready high drains one event per cycle.
- Pending counter update, priority top to bottom:
  - evt && acc: pending unchanged; total_cnt+1.
  - evt && !acc && pending < max: pending+1.
  - evt && !acc && pending == max: pending holds at max; overflow set; the event is lost.
  - !evt && acc: pending-1; total_cnt+1.
  - Otherwise pending holds.
  - A full counter with a simultaneous event and acceptance does not overflow.
- Overflow:
  - Sticky until ovf_clr.
  - If a set and ovf_clr occur in the same cycle, set wins and overflow stays 1.
- total_cnt: increments only on acc; wraps from 2^TOT_W-1 to 0 with no flag.
- Toggle rate: the transmitter guarantees at least 2 clk periods between toggles. Faster toggling may merge events; that is a protocol violation, not a block fault.
- Reset mid-operation: all queued events are discarded and the outputs return to their reset values. A toggle in flight at reset time is lost or counted once, never twice.

Decomposition:
- Shared package toggle_evt_pkg holds:
  - default constants SYNC_STAGES_DEF=2, CNT_W_DEF=3, TOT_W_DEF=16;
  - a function returning counter max = 2^CNT_W-1.
- Sub-module sync_chain (parameter STAGES; ports clk, rst, d, q) is instantiated once for tog_in and is reusable elsewhere.
- Edge detect, pending counter, overflow and total_cnt stay in toggle_event_decoder.

Test Plan (SYNC_STAGES=2, CNT_W=3, TOT_W=16; tog_in driven between edges):
- Reset/latency: hold rst for 3 cycles with tog_in=0 -> all outputs 0. Release rst, toggle tog_in 0->1 before edge E -> pending=1 and evt_valid=1 after edge E+2. evt_ready=1 at edge E+3 -> pending=0, total_cnt=1.
- Both polarities: evt_ready=0, toggle 0->1, wait 4 cycles, toggle 1->0 -> pending=2. Assert evt_ready for 2 cycles -> pending=0, total_cnt=2, evt_valid=0.
- Saturation: evt_ready=0, 9 toggles spaced 3 cycles apart -> pending stops at 7, overflow=1. Pulse ovf_clr -> overflow=0 and pending stays 7.
- Simultaneous event and acceptance at full: pending=7, evt_ready=1 in the cycle evt is high -> pending stays 7, overflow stays 0, total_cnt+1.
- Clear vs set: ovf_clr=1 in the same cycle as an overflowing event -> overflow=1.
- Reset mid-operation: pending=5, toggle in flight, assert rst for 1 cycle -> pending=0, overflow=0, total_cnt=0. Afterwards at most 1 event is counted from the in-flight toggle.

Source files
------------

// File: rtl/toggle_evt_pkg.sv
// Shared defaults and helpers for the toggle event decoder and its synchroniser.
package toggle_evt_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 3;
  localparam int TOT_W_DEF       = 16;

  // Largest value a pending counter of width w can hold.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/toggle_event_decoder_sync_chain.sv
// Plain multi-flop synchroniser for a single asynchronous level; STAGES cycles of latency, no backpressure.
// Flops are back-to-back with nothing between stages so metastability has a full period to settle.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s_q;
  logic [STAGES-1:0] s_d;

  always_comb begin
    s_d = {s_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign q = s_q[STAGES-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Recovers one event per tog_in transition, queues it in a saturating counter and hands events out over valid/ready.
// Latency: tog_in change before edge E shows in pending after edge E+SYNC_STAGES; evt_valid depends only on state.
module toggle_event_decoder
  import toggle_evt_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TOT_W       = TOT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic [TOT_W-1:0] total_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic             sync;
  logic             hist_q;
  logic             hist_d;
  logic [CNT_W-1:0] pending_q;
  logic [CNT_W-1:0] pending_d;
  logic             overflow_q;
  logic             overflow_d;
  logic [TOT_W-1:0] total_q;
  logic [TOT_W-1:0] total_d;
  logic             evt;
  logic             acc;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (tog_in),
    .q   (sync)
  );

  assign evt       = sync ^ hist_q;
  assign evt_valid = (pending_q != '0);
  assign acc       = evt_valid && evt_ready;

  always_comb begin
    hist_d     = sync;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    total_d    = total_q;

    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (acc) begin
      total_d = total_q + TOT_W'(1);
    end

    // An event arriving with an acceptance is a pass-through, so a full counter cannot overflow then.
    if (evt && !acc) begin
      if (pending_q == CNT_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + CNT_W'(1);
      end
    end else if (!evt && acc) begin
      pending_d = pending_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q     <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      total_q    <= '0;
    end else begin
      hist_q     <= hist_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      total_q    <= total_d;
    end
  end

  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign total_cnt = total_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed bench for toggle_event_decoder: latency, both polarities, saturation, clear-vs-set, mid-run reset.
module tb_toggle_event_decoder;

  logic        clk;
  logic        rst;
  logic        tog_in;
  logic        evt_valid;
  logic        evt_ready;
  logic [2:0]  pending;
  logic        overflow;
  logic        ovf_clr;
  logic [15:0] total_cnt;

  int n_cmp = 0;
  int n_err = 0;

  toggle_event_decoder #(
    .SYNC_STAGES (2),
    .CNT_W       (3),
    .TOT_W       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tog_in    (tog_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .pending   (pending),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .total_cnt (total_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit so sampling and driving stay off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    tog_in    = 1'b0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;

    // Reset held for three cycles
    repeat (3) step();
    chk("rst_pending",  32'(pending),   0);
    chk("rst_valid",    32'(evt_valid), 0);
    chk("rst_overflow", 32'(overflow),  0);
    chk("rst_total",    32'(total_cnt), 0);

    // Latency: toggle before edge E, visible after E+2
    rst = 1'b0;
    step();
    tog_in = 1'b1;
    step();
    step();
    chk("lat_pending_e1", 32'(pending), 0);
    step();
    chk("lat_pending_e2", 32'(pending),   1);
    chk("lat_valid_e2",   32'(evt_valid), 1);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("lat_drain_pending", 32'(pending),   0);
    chk("lat_drain_total",   32'(total_cnt), 1);

    // Both polarities counted
    tog_in = 1'b0;
    repeat (4) step();
    tog_in = 1'b1;
    repeat (4) step();
    chk("pol_pending", 32'(pending), 2);
    evt_ready = 1'b1;
    repeat (2) step();
    evt_ready = 1'b0;
    chk("pol_pending_drained", 32'(pending),   0);
    chk("pol_total",           32'(total_cnt), 3);
    chk("pol_valid",           32'(evt_valid), 0);

    // Saturation: nine events into a seven-deep counter
    for (int i = 0; i < 9; i++) begin
      tog_in = ~tog_in;
      repeat (3) step();
    end
    repeat (2) step();
    chk("sat_pending",  32'(pending),   7);
    chk("sat_overflow", 32'(overflow),  1);
    chk("sat_total",    32'(total_cnt), 3);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("clr_overflow", 32'(overflow), 0);
    chk("clr_pending",  32'(pending),  7);

    // Event coincident with acceptance while full
    tog_in = ~tog_in;
    step();
    step();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("sim_pending",  32'(pending),   7);
    chk("sim_overflow", 32'(overflow),  0);
    chk("sim_total",    32'(total_cnt), 4);

    // Clear in the same cycle as an overflowing event: set wins
    tog_in = ~tog_in;
    step();
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("setclr_overflow", 32'(overflow), 1);
    chk("setclr_pending",  32'(pending),  7);
    step();
    chk("setclr_sticky", 32'(overflow), 1);

    // Drain to five, then reset with a toggle in flight
    evt_ready = 1'b1;
    repeat (2) step();
    evt_ready = 1'b0;
    chk("mid_pending_pre", 32'(pending),   5);
    chk("mid_total_pre",   32'(total_cnt), 6);
    tog_in = ~tog_in;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_pending",  32'(pending),   0);
    chk("mid_rst_overflow", 32'(overflow),  0);
    chk("mid_rst_total",    32'(total_cnt), 0);
    chk("mid_rst_valid",    32'(evt_valid), 0);
    // tog_in is now 1, so exactly one event is recovered after release
    repeat (5) step();
    chk("post_rst_pending", 32'(pending),  1);
    chk("post_rst_valid",   32'(evt_valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
